// File: rtl/width_128to24_pkg.sv
// Shared constants for the 128-to-24 bit stream unpacker and its benches.
package width_128to24_pkg;
  localparam int IN_W_DEF        = 128;
  localparam int OUT_W_DEF       = 24;
  localparam int BUF_W_DEF       = IN_W_DEF + OUT_W_DEF;
  localparam int CNT_W_DEF       = 8;
  localparam int WORDS_PER_GROUP = 3;
  localparam int OUTS_PER_GROUP  = 16;

  typedef logic [OUT_W_DEF-1:0] out_word_t;
  typedef logic [IN_W_DEF-1:0]  in_word_t;
endpackage

// File: rtl/width_128to24_if.sv
// Valid/ready stream bundle: wide words in, narrow words out.
interface width_128to24_if
  import width_128to24_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
);
  logic             valid_in;
  logic [IN_W-1:0]  data_in;
  logic             ready_in;
  logic             valid_out;
  logic [OUT_W-1:0] data_out;
  logic             ready_out;

  modport master (
    output valid_in, data_in, ready_out,
    input  ready_in, valid_out, data_out
  );

  modport slave (
    input  valid_in, data_in, ready_out,
    output ready_in, valid_out, data_out
  );
endinterface

// File: rtl/width_128to24.sv
// Unpacks 128-bit words into MSB-first 24-bit words through a left-aligned
// residual buffer; a pop and a load may happen in the same cycle.
module width_128to24
  import width_128to24_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic              clk,
  input logic              rst_n,
  width_128to24_if.slave   bus
);
  localparam int BUF_W = IN_W + OUT_W;

  logic [BUF_W-1:0] buf_p0;
  logic [BUF_W-1:0] buf_nxt;
  logic [BUF_W-1:0] ins_word;
  logic [CNT_W-1:0] cnt_p0;
  logic [CNT_W-1:0] cnt_pop;
  logic [CNT_W-1:0] cnt_nxt;
  logic             valid_out;
  logic             ready_in;
  logic             pop;
  logic             load;

  assign valid_out     = (cnt_p0 >= CNT_W'(OUT_W));
  assign bus.valid_out = valid_out;
  assign bus.data_out  = buf_p0[BUF_W-1 -: OUT_W];

  assign pop      = valid_out && bus.ready_out;
  assign cnt_pop  = pop ? (cnt_p0 - CNT_W'(OUT_W)) : cnt_p0;
  assign ready_in = (cnt_pop < CNT_W'(OUT_W));
  assign bus.ready_in = ready_in;
  assign load     = bus.valid_in && ready_in;

  // Bits below the valid region are always zero, so the incoming word can be
  // OR-ed in just below whatever survives the pop.
  always_comb begin
    ins_word = {bus.data_in, {OUT_W{1'b0}}} >> cnt_pop;
    buf_nxt  = pop ? (buf_p0 << OUT_W) : buf_p0;
    cnt_nxt  = cnt_pop;
    if (load) begin
      buf_nxt = buf_nxt | ins_word;
      cnt_nxt = cnt_pop + CNT_W'(IN_W);
    end
  end

  // Stage p0: residual buffer and bit count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_p0 <= '0;
      cnt_p0 <= '0;
    end else begin
      buf_p0 <= buf_nxt;
      cnt_p0 <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_width_128to24.sv
// Directed and randomized bench for the 128-to-24 unpacker.
module tb_width_128to24;
  import width_128to24_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  width_128to24_if bus ();

  width_128to24 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic         vo;
  logic         ri;
  logic [23:0]  dout;
  logic [127:0] w [3];

  function automatic logic [127:0] mkword(input int base);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = 8'(base + i);
    return r;
  endfunction

  function automatic logic [23:0] exp_out(input int k);
    return {8'(3*k), 8'(3*k + 1), 8'(3*k + 2)};
  endfunction

  // Drive one cycle's inputs, sample combinational outputs, advance a clock.
  task automatic step(input logic vi, input logic [127:0] di, input logic ro);
    bus.valid_in  = vi;
    bus.data_in   = di;
    bus.ready_out = ro;
    #1;
    vo   = bus.valid_out;
    dout = bus.data_out;
    ri   = bus.ready_in;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.valid_in  = 1'b0;
    bus.data_in   = '0;
    bus.ready_out = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.valid_in  = 1'b0;
    bus.data_in   = '0;
    bus.ready_out = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid_out: got %b expected 0", bus.valid_out);
    end
    vectors++;
    if (bus.data_out !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_data_out: got %h expected 000000", bus.data_out);
    end
    vectors++;
    if (bus.ready_in !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready_in: got %b expected 1", bus.ready_in);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int nout = 0;
    int wi   = 0;
    logic vi;
    do_reset();
    for (int c = 0; c < 40 && nout < 16; c++) begin
      vi = (wi < 3);
      step(vi, (wi < 3) ? w[wi] : w[0], 1'b1);
      if (c < 16) begin
        vectors++;
        if (ri !== (c == 0 || c == 5 || c == 10)) begin
          miscompares++;
          $display("FAIL b2b_ready_in cycle %0d: got %b expected %b", c, ri, (c == 0 || c == 5 || c == 10));
        end
      end
      if (c >= 1 && c <= 16) begin
        vectors++;
        if (vo !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_valid_out cycle %0d: got %b expected 1", c, vo);
        end
      end
      if (vo === 1'b1) begin
        vectors++;
        if (dout !== exp_out(nout)) begin
          miscompares++;
          $display("FAIL b2b_data out %0d: got %h expected %h", nout, dout, exp_out(nout));
        end
        nout++;
      end
      if (vi && ri === 1'b1) wi++;
    end
    vectors++;
    if (nout != 16) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d outputs expected 16", nout);
    end
    vectors++;
    if (dut.cnt_p0 !== 8'd0 || bus.valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drained: got cnt %0d valid %b expected cnt 0 valid 0", dut.cnt_p0, bus.valid_out);
    end
  endtask

  task automatic test_backpressure();
    int   nout = 0;
    int   wi   = 0;
    int   mcnt = 0;
    logic vi, ro, exp_vo, exp_ri, mpop;
    logic pvo = 1'b0, pro = 1'b1;
    logic [23:0] pdout = '0;
    do_reset();
    for (int c = 0; c < 200 && nout < 16; c++) begin
      vi = (wi < 3);
      ro = (c % 4 == 0) || (c % 4 == 3);
      step(vi, (wi < 3) ? w[wi] : w[0], ro);
      exp_vo = (mcnt >= 24);
      mpop   = exp_vo && ro;
      exp_ri = ((mcnt - (mpop ? 24 : 0)) < 24);
      vectors++;
      if (vo !== exp_vo || ri !== exp_ri) begin
        miscompares++;
        $display("FAIL bp_handshake cycle %0d: got valid %b ready %b expected valid %b ready %b", c, vo, ri, exp_vo, exp_ri);
      end
      if (pvo && !pro) begin
        vectors++;
        if (vo !== 1'b1 || dout !== pdout) begin
          miscompares++;
          $display("FAIL bp_hold cycle %0d: got valid %b data %h expected valid 1 data %h", c, vo, dout, pdout);
        end
      end
      if (mpop) begin
        vectors++;
        if (dout !== exp_out(nout)) begin
          miscompares++;
          $display("FAIL bp_data out %0d: got %h expected %h", nout, dout, exp_out(nout));
        end
        nout++;
        mcnt -= 24;
      end
      if (vi && exp_ri) begin
        wi++;
        mcnt += 128;
      end
      pvo = vo; pro = ro; pdout = dout;
    end
    vectors++;
    if (nout != 16) begin
      miscompares++;
      $display("FAIL bp_count: got %0d outputs expected 16", nout);
    end
  endtask

  task automatic test_gap();
    int nout = 0;
    do_reset();
    step(1'b1, w[0], 1'b1);
    for (int c = 0; c < 10; c++) begin
      step(1'b0, w[0], 1'b1);
      if (vo === 1'b1) begin
        vectors++;
        if (dout !== exp_out(nout)) begin
          miscompares++;
          $display("FAIL gap_data out %0d: got %h expected %h", nout, dout, exp_out(nout));
        end
        nout++;
      end
    end
    vectors++;
    if (nout != 5) begin
      miscompares++;
      $display("FAIL gap_count: got %0d outputs expected 5", nout);
    end
    vectors++;
    if (dut.cnt_p0 !== 8'd8 || bus.valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL gap_tail: got cnt %0d valid %b expected cnt 8 valid 0", dut.cnt_p0, bus.valid_out);
    end
    step(1'b1, w[1], 1'b1);
    vectors++;
    if (ri !== 1'b1 || vo !== 1'b0) begin
      miscompares++;
      $display("FAIL gap_reload: got ready %b valid %b expected ready 1 valid 0", ri, vo);
    end
    step(1'b0, w[0], 1'b0);
    vectors++;
    if (vo !== 1'b1 || dout !== 24'h0F1011) begin
      miscompares++;
      $display("FAIL gap_span: got valid %b data %h expected valid 1 data 0f1011", vo, dout);
    end
  endtask

  task automatic test_coincide();
    do_reset();
    step(1'b1, w[0], 1'b1);
    for (int c = 0; c < 4; c++) step(1'b0, w[0], 1'b1);
    step(1'b1, w[1], 1'b1);
    vectors++;
    if (vo !== 1'b1 || ri !== 1'b1 || dout !== 24'h0C0D0E) begin
      miscompares++;
      $display("FAIL coincide_cycle: got valid %b ready %b data %h expected 1 1 0c0d0e", vo, ri, dout);
    end
    vectors++;
    if (dut.cnt_p0 !== 8'd136) begin
      miscompares++;
      $display("FAIL coincide_cnt: got %0d expected 136", dut.cnt_p0);
    end
    vectors++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== 24'h0F1011) begin
      miscompares++;
      $display("FAIL coincide_nobubble: got valid %b data %h expected 1 0f1011", bus.valid_out, bus.data_out);
    end
  endtask

  task automatic test_reset_mid();
    int nout = 0;
    int wi   = 0;
    logic vi;
    do_reset();
    for (int c = 0; c < 40 && nout < 7; c++) begin
      vi = (wi < 2);
      step(vi, (wi < 2) ? w[wi] : w[0], 1'b1);
      if (vo === 1'b1) nout++;
      if (vi && ri === 1'b1) wi++;
    end
    bus.valid_in  = 1'b0;
    bus.ready_out = 1'b1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.valid_out !== 1'b0 || bus.data_out !== 24'h0 || bus.ready_in !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_async: got valid %b data %h ready %b expected 0 000000 1", bus.valid_out, bus.data_out, bus.ready_in);
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 128'hFFEEDDCC_BBAA9988_77665544_33221100, 1'b0);
    step(1'b0, '0, 1'b0);
    vectors++;
    if (vo !== 1'b1 || dout !== 24'hFFEEDD) begin
      miscompares++;
      $display("FAIL midreset_first: got valid %b data %h expected 1 ffeedd", vo, dout);
    end
  endtask

  task automatic test_random();
    bit           bq [$];
    int           wi   = 0;
    int           npop = 0;
    logic         vi, ro, exp_vo, exp_ri, mpop;
    logic [127:0] d;
    logic [23:0]  e;
    bit           done = 0;
    do_reset();
    for (int c = 0; c < 20000; c++) begin
      if (wi == 300 && bq.size() < 24) begin
        done = 1;
        break;
      end
      vi = (wi < 300) && ($urandom_range(0, 3) != 0);
      ro = ($urandom_range(0, 2) != 0);
      d  = {$urandom, $urandom, $urandom, $urandom};
      step(vi, d, ro);
      exp_vo = (bq.size() >= 24);
      mpop   = exp_vo && ro;
      exp_ri = ((bq.size() - (mpop ? 24 : 0)) < 24);
      vectors++;
      if (vo !== exp_vo || ri !== exp_ri) begin
        miscompares++;
        $display("FAIL rand_handshake cycle %0d: got valid %b ready %b expected valid %b ready %b", c, vo, ri, exp_vo, exp_ri);
      end
      if (mpop) begin
        for (int j = 0; j < 24; j++) e[23-j] = bq[j];
        vectors++;
        if (dout !== e) begin
          miscompares++;
          $display("FAIL rand_data out %0d: got %h expected %h", npop, dout, e);
        end
        for (int j = 0; j < 24; j++) void'(bq.pop_front());
        npop++;
      end
      if (vi && exp_ri) begin
        for (int j = 127; j >= 0; j--) bq.push_back(d[j]);
        wi++;
      end
    end
    vectors++;
    if (!done || npop != 1600) begin
      miscompares++;
      $display("FAIL rand_total: got %0d outputs (finished %0d) expected 1600", npop, done);
    end
  endtask

  initial begin
    bus.valid_in  = 1'b0;
    bus.data_in   = '0;
    bus.ready_out = 1'b0;
    for (int i = 0; i < WORDS_PER_GROUP; i++) w[i] = mkword(16 * i);
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_gap();
    test_coincide();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
